// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Arbiter FSM states; kept apart from the core's own state enum.
    typedef enum logic [1:0] {
        IDLE_A  = 2'd0,
        ISSUE_A = 2'd1,
        WAIT_A  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit at or after start, wrapping.
// The request vector is doubled and shifted down by start so a plain
// lowest-bit priority search covers the wrapped range.
module rr_picker #(
    parameter int width = 4
) (
    input  logic [width-1:0]         req_i,
    input  logic [$clog2(width)-1:0] start_i,
    output logic                     found_o,
    output logic [$clog2(width)-1:0] index_o
);

    localparam int iw = $clog2(width);
    localparam logic [iw:0] width_l = (iw+1)'(width);

    logic [width-1:0] rot;
    logic [iw-1:0]    off;
    logic [iw:0]      sum;

    // rotate, priority-search lowest set bit, then map offset back to a core index
    always_comb begin
        rot     = width'({req_i, req_i} >> start_i);
        found_o = 1'b0;
        off     = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = iw'(i);
            end
        end
        sum     = {1'b0, start_i} + {1'b0, off};
        index_o = (sum >= width_l) ? iw'(sum - width_l) : sum[iw-1:0];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between several cores.
// One transaction in flight at a time: IDLE (arbitrate) -> ISSUE (request)
// -> WAIT (response) -> IDLE.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int num_cores_p  = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [num_cores_p-1:0]                core_valid_i,
    input  logic [num_cores_p-1:0]                core_wen_i,
    input  logic [num_cores_p-1:0]                core_byte_i,
    input  logic [num_cores_p*addr_width_p-1:0]   core_addr_i,
    input  logic [num_cores_p*data_width_p-1:0]   core_wdata_i,
    output logic [num_cores_p-1:0]                core_yumi_o,
    output logic [num_cores_p-1:0]                core_rvalid_o,
    output logic [data_width_p-1:0]               core_rdata_o,
    input  logic [num_cores_p-1:0]                core_ryumi_i,
    output logic                                  mem_valid_o,
    output logic                                  mem_wen_o,
    output logic                                  mem_byte_o,
    output logic [addr_width_p-1:0]               mem_addr_o,
    output logic [data_width_p-1:0]               mem_wdata_o,
    input  logic                                  mem_yumi_i,
    input  logic                                  mem_rvalid_i,
    input  logic [data_width_p-1:0]               mem_rdata_i,
    output logic                                  mem_ryumi_o,
    output logic [$clog2(num_cores_p)-1:0]        grant_o,
    output logic                                  busy_o,
    output logic                                  error_o
);

    localparam int gw = $clog2(num_cores_p);
    localparam logic [gw-1:0] last_core = gw'(num_cores_p - 1);

    arb_state_e state_r, state_n;
    logic [gw-1:0] grant_r, grant_n;
    logic [gw-1:0] rr_ptr_r, rr_ptr_n;
    logic          error_r, error_set;

    logic          pick_found;
    logic [gw-1:0] pick_idx;

    logic [num_cores_p-1:0]  grant_oh;
    logic                    sel_valid, sel_wen, sel_byte, sel_ryumi;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_wdata;

    rr_picker #(.width(num_cores_p)) u_picker (
        .req_i   (core_valid_i),
        .start_i (rr_ptr_r),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    assign grant_oh = num_cores_p'(1) << grant_r;
    assign grant_o  = grant_r;
    assign busy_o   = (state_r != IDLE_A);
    assign error_o  = error_r;

    // select the granted core's request and ack fields
    always_comb begin
        sel_valid = 1'b0;
        sel_wen   = 1'b0;
        sel_byte  = 1'b0;
        sel_ryumi = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < num_cores_p; i++) begin
            if (grant_r == gw'(i)) begin
                sel_valid = core_valid_i[i];
                sel_wen   = core_wen_i[i];
                sel_byte  = core_byte_i[i];
                sel_ryumi = core_ryumi_i[i];
                sel_addr  = core_addr_i[i*addr_width_p +: addr_width_p];
                sel_wdata = core_wdata_i[i*data_width_p +: data_width_p];
            end
        end
    end

    // next state, pointer update, handshake routing and protocol-error detection
    always_comb begin
        state_n       = state_r;
        grant_n       = grant_r;
        rr_ptr_n      = rr_ptr_r;
        error_set     = 1'b0;
        mem_valid_o   = 1'b0;
        mem_wen_o     = 1'b0;
        mem_byte_o    = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_ryumi_o   = 1'b0;
        core_yumi_o   = '0;
        core_rvalid_o = '0;
        core_rdata_o  = '0;
        case (state_r)
            IDLE_A: begin
                // a response with nothing outstanding is dropped
                error_set = mem_rvalid_i;
                if (pick_found) begin
                    grant_n = pick_idx;
                    state_n = ISSUE_A;
                end
            end
            ISSUE_A: begin
                error_set   = mem_rvalid_i;
                mem_valid_o = sel_valid;
                mem_wen_o   = sel_wen;
                mem_byte_o  = sel_byte;
                mem_addr_o  = sel_addr;
                mem_wdata_o = sel_wdata;
                core_yumi_o = grant_oh & {num_cores_p{mem_yumi_i}};
                if (!sel_valid) begin
                    // withdrawn request: no traffic, pointer keeps its place
                    state_n = IDLE_A;
                end else if (mem_yumi_i) begin
                    state_n = WAIT_A;
                end
            end
            WAIT_A: begin
                core_rvalid_o = grant_oh & {num_cores_p{mem_rvalid_i}};
                core_rdata_o  = mem_rdata_i;
                mem_ryumi_o   = sel_ryumi;
                if (mem_rvalid_i && sel_ryumi) begin
                    state_n  = IDLE_A;
                    rr_ptr_n = (grant_r == last_core) ? '0 : grant_r + gw'(1);
                end
            end
            default: state_n = IDLE_A;
        endcase
        if (mem_yumi_i && !mem_valid_o) begin
            error_set = 1'b1;
        end
    end

    // state, grant, rotation pointer and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE_A;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            rr_ptr_r <= rr_ptr_n;
            error_r  <= error_r | error_set;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, hand sequences for
// stalls / withdrawal / errors / async reset, and a randomized run checked
// against a modular-arithmetic round-robin model.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    cv, cwen, cbyte, cryumi;
    logic [AW-1:0]   c_addr  [N];
    logic [DW-1:0]   c_wdata [N];
    logic [N*AW-1:0] addr_v;
    logic [N*DW-1:0] wdata_v;

    logic [N-1:0]  core_yumi_o, core_rvalid_o;
    logic [DW-1:0] core_rdata_o;
    logic          mem_valid_o, mem_wen_o, mem_byte_o, mem_ryumi_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_yumi_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic [1:0]    grant_o;
    logic          busy_o, error_o;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [N-1:0]  mask;
        int            g;
        logic          wen;
        logic          byt;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    always_comb begin
        addr_v  = '0;
        wdata_v = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i*AW +: AW]  = c_addr[i];
            wdata_v[i*DW +: DW] = c_wdata[i];
        end
    end

    dmem_arbiter #(.num_cores_p(N), .addr_width_p(AW), .data_width_p(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_valid_i  (cv),
        .core_wen_i    (cwen),
        .core_byte_i   (cbyte),
        .core_addr_i   (addr_v),
        .core_wdata_i  (wdata_v),
        .core_yumi_o   (core_yumi_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .core_ryumi_i  (cryumi),
        .mem_valid_o   (mem_valid_o),
        .mem_wen_o     (mem_wen_o),
        .mem_byte_o    (mem_byte_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_yumi_i    (mem_yumi_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_ryumi_o   (mem_ryumi_o),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .error_o       (error_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] r;
        r    = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // reference round-robin choice: scan (p+k) mod N
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        cv = '0; cwen = '0; cbyte = '0; cryumi = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i]  = '0;
            c_wdata[i] = '0;
        end
        mem_yumi_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic set_core(input int c, input logic w, input logic b,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        cwen[c] = w; cbyte[c] = b; c_addr[c] = a; c_wdata[c] = d; cv[c] = 1'b1;
    endtask

    // zero-wait transaction starting in an IDLE cycle with valids already driven
    task automatic txn_zero(input int g, input logic [AW-1:0] ea, input logic [DW-1:0] ew,
                            input logic ewen, input logic eb, input logic [DW-1:0] rd);
        #1;
        chk("idle_busy", 64'(busy_o), 64'(0));
        step();
        mem_yumi_i = 1'b1;
        #1;
        chk("iss_grant", 64'(grant_o), 64'(g));
        chk("iss_mem_valid", 64'(mem_valid_o), 64'(1));
        chk("iss_addr", 64'(mem_addr_o), 64'(ea));
        chk("iss_wdata", 64'(mem_wdata_o), 64'(ew));
        chk("iss_wen", 64'(mem_wen_o), 64'(ewen));
        chk("iss_byte", 64'(mem_byte_o), 64'(eb));
        chk("iss_yumi", 64'(core_yumi_o), 64'(oh(g)));
        step();
        mem_yumi_i = 1'b0; cv[g] = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = rd; cryumi = oh(g);
        #1;
        chk("wait_rvalid", 64'(core_rvalid_o), 64'(oh(g)));
        chk("wait_rdata", 64'(core_rdata_o), 64'(rd));
        chk("wait_ryumi", 64'(mem_ryumi_o), 64'(1));
        chk("wait_mem_valid", 64'(mem_valid_o), 64'(0));
        step();
        mem_rvalid_i = 1'b0; cryumi = '0; mem_rdata_i = '0;
        #1;
        chk("done_busy", 64'(busy_o), 64'(0));
    endtask

    task automatic rand_txns(input int n);
        int ptr, g, yd, rdl, kd;
        logic [DW-1:0] d;
        ptr = 0;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!cv[c] && $urandom_range(0, 1) == 1)
                    set_core(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (cv == '0) begin
                g = $urandom_range(0, N - 1);
                set_core(g, 1'b0, 1'b0, $urandom, $urandom);
            end
            g = rr_pick(cv, ptr);
            #1;
            chk("r_idle_busy", 64'(busy_o), 64'(0));
            step();
            yd = $urandom_range(0, 3);
            repeat (yd) begin
                chk("r_stall_valid", 64'(mem_valid_o), 64'(1));
                chk("r_stall_grant", 64'(grant_o), 64'(g));
                chk("r_stall_yumi", 64'(core_yumi_o), 64'(0));
                step();
            end
            mem_yumi_i = 1'b1;
            #1;
            chk("r_yumi", 64'(core_yumi_o), 64'(oh(g)));
            chk("r_addr", 64'(mem_addr_o), 64'(c_addr[g]));
            chk("r_wdata", 64'(mem_wdata_o), 64'(c_wdata[g]));
            chk("r_wen_byte", 64'({mem_wen_o, mem_byte_o}), 64'({cwen[g], cbyte[g]}));
            step();
            mem_yumi_i = 1'b0; cv[g] = 1'b0;
            rdl = $urandom_range(0, 3);
            repeat (rdl) begin
                #1;
                chk("r_wait_valid", 64'(mem_valid_o), 64'(0));
                chk("r_wait_rvalid", 64'(core_rvalid_o), 64'(0));
                step();
            end
            d = $urandom;
            mem_rvalid_i = 1'b1; mem_rdata_i = d;
            kd = $urandom_range(0, 2);
            repeat (kd) begin
                cryumi = N'($urandom) & ~oh(g);
                #1;
                chk("r_rvalid", 64'(core_rvalid_o), 64'(oh(g)));
                chk("r_rdata", 64'(core_rdata_o), 64'(d));
                chk("r_ryumi_hold", 64'(mem_ryumi_o), 64'(0));
                step();
            end
            cryumi = oh(g);
            #1;
            chk("r_ryumi", 64'(mem_ryumi_o), 64'(1));
            step();
            mem_rvalid_i = 1'b0; cryumi = '0;
            ptr = (g + 1) % N;
        end
    endtask

    initial begin
        tbl[0] = '{4'b0100, 2, 1'b0, 1'b0, 32'h40,  32'h0,  32'hDEADBEEF};
        tbl[1] = '{4'b0010, 1, 1'b1, 1'b1, 32'h7,   32'hAB, 32'h0};
        tbl[2] = '{4'b1001, 3, 1'b0, 1'b0, 32'h300, 32'h31, 32'h1111};
        tbl[3] = '{4'b1001, 0, 1'b1, 1'b0, 32'h400, 32'h41, 32'h2222};
        tbl[4] = '{4'b0001, 0, 1'b0, 1'b1, 32'h500, 32'h51, 32'h3333};
        tbl[5] = '{4'b1110, 1, 1'b0, 1'b0, 32'h600, 32'h61, 32'h4444};
        tbl[6] = '{4'b0011, 0, 1'b1, 1'b1, 32'h700, 32'h71, 32'h5555};
        tbl[7] = '{4'b0100, 2, 1'b0, 1'b0, 32'h800, 32'h81, 32'h6666};

        clear_inputs();
        #2;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        chk("rst_outs", 64'({mem_valid_o, mem_ryumi_o, core_yumi_o, core_rvalid_o}), 64'(0));
        chk("rst_data", 64'({mem_addr_o, core_rdata_o}), 64'(0));
        reset_dut();

        // directed table; pointer carries across entries
        for (int e = 0; e < 8; e++) begin
            cv = '0;
            for (int c = 0; c < N; c++) begin
                if (tbl[e].mask[c])
                    set_core(c, tbl[e].wen, tbl[e].byt,
                             (c == tbl[e].g) ? tbl[e].addr : 32'hBAD0_0000 + 32'(c),
                             (c == tbl[e].g) ? tbl[e].wdata : 32'hEE);
            end
            txn_zero(tbl[e].g, tbl[e].addr, tbl[e].wdata, tbl[e].wen, tbl[e].byt, tbl[e].rdata);
        end
        cv = '0;

        // all four cores always requesting: 0,1,2,3,0
        reset_dut();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < N; c++) set_core(c, 1'b0, 1'b0, 32'hBAD0_0000 + 32'(c), 32'h5A00 + 32'(c));
            txn_zero(k % N, 32'hBAD0_0000 + 32'(k % N), 32'h5A00 + 32'(k % N), 1'b0, 1'b0, 32'(k));
        end
        cv = '0;

        // memory stalls with another core waiting
        reset_dut();
        set_core(0, 1'b0, 1'b0, 32'h100, 32'h11);
        set_core(3, 1'b1, 1'b0, 32'h300, 32'h33);
        #1;
        step();
        repeat (5) begin
            #1;
            chk("st_valid", 64'(mem_valid_o), 64'(1));
            chk("st_addr", 64'(mem_addr_o), 64'(32'h100));
            chk("st_grant", 64'(grant_o), 64'(0));
            chk("st_yumi0", 64'(core_yumi_o), 64'(0));
            step();
        end
        mem_yumi_i = 1'b1;
        #1;
        chk("st_yumi", 64'(core_yumi_o), 64'(4'b0001));
        step();
        mem_yumi_i = 1'b0; cv[0] = 1'b0;
        repeat (7) begin
            #1;
            chk("st_wait_valid", 64'(mem_valid_o), 64'(0));
            chk("st_wait_rvalid", 64'(core_rvalid_o), 64'(0));
            chk("st_wait_grant", 64'(grant_o), 64'(0));
            step();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE0001; cryumi = 4'b1000;
        repeat (2) begin
            #1;
            chk("st_rvalid", 64'(core_rvalid_o), 64'(4'b0001));
            chk("st_ryumi_hold", 64'(mem_ryumi_o), 64'(0));
            step();
        end
        cryumi = 4'b0001;
        #1;
        chk("st_ryumi", 64'(mem_ryumi_o), 64'(1));
        step();
        mem_rvalid_i = 1'b0; cryumi = '0;
        txn_zero(3, 32'h300, 32'h33, 1'b1, 1'b0, 32'h77);

        // withdrawal in ISSUE, then protocol errors
        reset_dut();
        set_core(0, 1'b0, 1'b0, 32'h80, 32'h0);
        #1;
        step();
        cv[0] = 1'b0;
        #1;
        chk("wd_no_valid", 64'(mem_valid_o), 64'(0));
        step();
        chk("wd_idle", 64'(busy_o), 64'(0));
        set_core(0, 1'b0, 1'b0, 32'h80, 32'h0);
        set_core(1, 1'b0, 1'b0, 32'h90, 32'h0);
        txn_zero(0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h9);
        cv = '0;
        mem_rvalid_i = 1'b1;
        #1;
        chk("err_no_fwd", 64'(core_rvalid_o), 64'(0));
        chk("err_pre", 64'(error_o), 64'(0));
        step();
        mem_rvalid_i = 1'b0;
        chk("err_rvalid", 64'(error_o), 64'(1));
        repeat (3) step();
        chk("err_sticky", 64'(error_o), 64'(1));
        reset_dut();
        chk("err_clr", 64'(error_o), 64'(0));
        mem_yumi_i = 1'b1;
        step();
        mem_yumi_i = 1'b0;
        chk("err_yumi", 64'(error_o), 64'(1));

        // async reset in WAIT
        reset_dut();
        set_core(2, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        step();
        mem_yumi_i = 1'b1;
        step();
        mem_yumi_i = 1'b0; cv = '0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234; cryumi = 4'b0100;
        #1;
        chk("ar_pre_rvalid", 64'(core_rvalid_o), 64'(4'b0100));
        reset = 1'b1;
        #1;
        chk("ar_busy", 64'(busy_o), 64'(0));
        chk("ar_outs", 64'({core_rvalid_o, mem_ryumi_o, mem_valid_o}), 64'(0));
        chk("ar_rdata", 64'(core_rdata_o), 64'(0));
        chk("ar_grant", 64'(grant_o), 64'(0));
        reset = 1'b0;
        mem_rvalid_i = 1'b0; cryumi = '0; mem_rdata_i = '0;
        step();
        set_core(1, 1'b1, 1'b0, 32'hC0, 32'h5);
        txn_zero(1, 32'hC0, 32'h5, 1'b1, 1'b0, 32'hA5);

        // randomized traffic against the model
        reset_dut();
        rand_txns(60);
        chk("rand_no_error", 64'(error_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
